// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the integer execute stage: opcodes, funct3 encodings
// and the CDB result entry.
package alu_exec_unit_pkg;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BR2  = 3'b010,
    F3_BR3  = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  typedef struct packed {
    logic [4:0]  rob_id;
    logic [31:0] value;
  } cdb_entry_t;

endpackage

// File: rtl/alu_exec_unit_fifo.sv
// Result FIFO between ALU compute and the CDB slot: pointers, count,
// registered almost-full threshold, sticky overflow and synchronous flush.
module alu_result_fifo
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       flush,
  input  logic       push_req,
  input  cdb_entry_t wdata,
  input  logic       pop_req,
  output cdb_entry_t rdata,
  output logic       not_empty,
  output logic       almost_full,
  output logic       ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_THR  = CW'(DEPTH - 2);

  cdb_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_almost_full;
  logic            r_ovf;

  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_do_push;
  logic [CW-1:0]   w_count_nxt;

  assign w_full    = (r_count == C_FULL);
  assign w_push    = push_req && rdy && !flush;
  assign w_pop     = pop_req && (r_count != '0) && rdy && !flush;
  // A pop in the same cycle frees the slot, so a push at full is still legal.
  assign w_do_push = w_push && (!w_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push && !w_pop)      w_count_nxt = r_count + 1'b1;
    else if (!w_do_push && w_pop) w_count_nxt = r_count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
      r_ovf         <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_almost_full <= 1'b0;
    end else if (rdy) begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      r_count       <= w_count_nxt;
      r_almost_full <= (w_count_nxt >= C_THR);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // Head is forced to zero when empty so reset clears outputs without touching storage.
  assign not_empty   = (r_count != '0);
  assign rdata       = not_empty ? r_mem[r_rd_ptr] : '0;
  assign almost_full = r_almost_full;
  assign ovf         = r_ovf;

endmodule

// File: rtl/alu_exec_unit.sv
// RV32I integer execute stage: combinational compute of the issued op,
// results queued in alu_result_fifo and offered on the ALU CDB slot.
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic        _alu_ready,
  input  logic [4:0]  _alu_rob_id,
  input  logic [6:0]  _alu_type,
  input  logic [3:0]  _alu_op,
  input  logic [31:0] _alu_v1,
  input  logic [31:0] _alu_v2,
  output logic        _alu_full,
  input  logic        _cdb_grant,
  output logic        _cdb_ready,
  output logic [4:0]  _cdb_rob_id,
  output logic [31:0] _cdb_value,
  output logic        _alu_ovf
);

  logic [31:0] w_result;
  logic        w_alt;
  logic [4:0]  w_shamt;
  logic        w_lt;
  logic        w_ltu;
  alu_f3_e     w_f3;
  br_f3_e      w_bf3;
  cdb_entry_t  w_wdata;
  cdb_entry_t  w_head;

  assign w_f3    = alu_f3_e'(_alu_op[2:0]);
  assign w_bf3   = br_f3_e'(_alu_op[2:0]);
  assign w_shamt = _alu_v2[4:0];
  assign w_lt    = $signed(_alu_v1) < $signed(_alu_v2);
  assign w_ltu   = _alu_v1 < _alu_v2;
  // funct7[5] selects sub/sra for R-type; for I-type only srai uses it.
  assign w_alt   = _alu_op[3] && ((_alu_type == OP_R) || (w_f3 == F3_SR));

  always_comb begin
    w_result = _alu_v1 + _alu_v2;
    if ((_alu_type == OP_R) || (_alu_type == OP_I)) begin
      case (w_f3)
        F3_ADD:  w_result = w_alt ? (_alu_v1 - _alu_v2) : (_alu_v1 + _alu_v2);
        F3_SLL:  w_result = _alu_v1 << w_shamt;
        F3_SLT:  w_result = {31'd0, w_lt};
        F3_SLTU: w_result = {31'd0, w_ltu};
        F3_XOR:  w_result = _alu_v1 ^ _alu_v2;
        F3_SR:   w_result = w_alt ? 32'($signed(_alu_v1) >>> w_shamt) : (_alu_v1 >> w_shamt);
        F3_OR:   w_result = _alu_v1 | _alu_v2;
        F3_AND:  w_result = _alu_v1 & _alu_v2;
        default: w_result = '0;
      endcase
    end else if (_alu_type == OP_BR) begin
      case (w_bf3)
        F3_BEQ:  w_result = {31'd0, _alu_v1 == _alu_v2};
        F3_BNE:  w_result = {31'd0, _alu_v1 != _alu_v2};
        F3_BLT:  w_result = {31'd0, w_lt};
        F3_BGE:  w_result = {31'd0, !w_lt};
        F3_BLTU: w_result = {31'd0, w_ltu};
        F3_BGEU: w_result = {31'd0, !w_ltu};
        default: w_result = '0;
      endcase
    end
  end

  assign w_wdata.rob_id = _alu_rob_id;
  assign w_wdata.value  = w_result;

  alu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .rdy         (rdy_in),
    .flush       (_clear),
    .push_req    (_alu_ready),
    .wdata       (w_wdata),
    .pop_req     (_cdb_grant),
    .rdata       (w_head),
    .not_empty   (_cdb_ready),
    .almost_full (_alu_full),
    .ovf         (_alu_ovf)
  );

  assign _cdb_rob_id = w_head.rob_id;
  assign _cdb_value  = w_head.value;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: stimulus pushes expected CDB entries,
// a monitor pops and compares on every granted head.
module tb_alu_exec_unit;

  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BR  = 7'b1100011;
  localparam logic [6:0] T_LUI = 7'b0110111;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        _clear;
  logic        _alu_ready;
  logic [4:0]  _alu_rob_id;
  logic [6:0]  _alu_type;
  logic [3:0]  _alu_op;
  logic [31:0] _alu_v1;
  logic [31:0] _alu_v2;
  logic        _alu_full;
  logic        _cdb_grant;
  logic        _cdb_ready;
  logic [4:0]  _cdb_rob_id;
  logic [31:0] _cdb_value;
  logic        _alu_ovf;

  logic [36:0] sb [$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  alu_exec_unit #(.DEPTH(4)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    ._clear      (_clear),
    ._alu_ready  (_alu_ready),
    ._alu_rob_id (_alu_rob_id),
    ._alu_type   (_alu_type),
    ._alu_op     (_alu_op),
    ._alu_v1     (_alu_v1),
    ._alu_v2     (_alu_v2),
    ._alu_full   (_alu_full),
    ._cdb_grant  (_cdb_grant),
    ._cdb_ready  (_cdb_ready),
    ._cdb_rob_id (_cdb_rob_id),
    ._cdb_value  (_cdb_value),
    ._alu_ovf    (_alu_ovf)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk_in) begin
    if (rst_n_in && rdy_in && !_clear && _cdb_grant && _cdb_ready) begin
      if (sb.size() == 0) begin
        chk("cdb_unexpected", {27'd0, _cdb_rob_id, _cdb_value}, 64'h1_0000_0000_0000);
      end else begin
        chk("cdb_entry", {27'd0, _cdb_rob_id, _cdb_value}, {27'd0, sb[0]});
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rob, input logic [6:0] ty, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit accepted);
    _alu_ready  = 1'b1;
    _alu_rob_id = rob;
    _alu_type   = ty;
    _alu_op     = op;
    _alu_v1     = a;
    _alu_v2     = b;
    if (accepted) sb.push_back({rob, exp});
    step();
    _alu_ready = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    _cdb_grant = 1'b1;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    _cdb_grant = 1'b0;
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_cdb_ready", {63'd0, _cdb_ready}, 64'd0);
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; _clear = 1'b0; _alu_ready = 1'b0;
    _alu_rob_id = '0; _alu_type = '0; _alu_op = '0; _alu_v1 = '0; _alu_v2 = '0;
    _cdb_grant = 1'b0;
    #12;
    chk("rst_ready", {63'd0, _cdb_ready}, 64'd0);
    chk("rst_value", {27'd0, _cdb_rob_id, _cdb_value}, 64'd0);
    chk("rst_flags", {62'd0, _alu_full, _alu_ovf}, 64'd0);
    rst_n_in = 1'b1;
    step();

    // sub, single entry latency and grant
    issue(5'd3, T_R, 4'b1000, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1);
    chk("lat_ready", {63'd0, _cdb_ready}, 64'd1);
    _cdb_grant = 1'b1;
    step();
    _cdb_grant = 1'b0;
    chk("grant_empties", {63'd0, _cdb_ready}, 64'd0);

    // I-type and assorted R-type / other types
    issue(5'd4, T_I, 4'b1101, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1'b1);
    issue(5'd5, T_I, 4'b1000, 32'd1, 32'd2, 32'd3, 1'b1);
    issue(5'd6, T_R, 4'b0001, 32'h0000_0003, 32'd4, 32'h0000_0030, 1'b1);
    drain();
    issue(5'd7, T_R, 4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b1);
    issue(5'd8, T_R, 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
    issue(5'd9, T_LUI, 4'b0000, 32'h1234_0000, 32'h0000_0567, 32'h1234_0567, 1'b1);
    drain();

    // branches with continuous grant
    _cdb_grant = 1'b1;
    issue(5'd1, T_BR, 4'b0100, 32'hFFFF_FFFF, 32'd0, 32'd1, 1'b1);
    issue(5'd2, T_BR, 4'b0110, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1);
    issue(5'd3, T_BR, 4'b0101, 32'd5, 32'd5, 32'd1, 1'b1);
    issue(5'd4, T_BR, 4'b0001, 32'd5, 32'd5, 32'd0, 1'b1);
    issue(5'd5, T_BR, 4'b0010, 32'd5, 32'd5, 32'd0, 1'b1);
    drain();

    // backpressure, fill, overflow
    issue(5'd10, T_R, 4'b0000, 32'd10, 32'd1, 32'd11, 1'b1);
    chk("full_at_1", {63'd0, _alu_full}, 64'd0);
    issue(5'd11, T_R, 4'b0100, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1'b1);
    chk("full_at_2", {63'd0, _alu_full}, 64'd1);
    issue(5'd12, T_R, 4'b0110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b1);
    issue(5'd13, T_R, 4'b0111, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b1);
    chk("no_ovf_at_4", {63'd0, _alu_ovf}, 64'd0);
    issue(5'd31, T_R, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
    chk("ovf_set", {63'd0, _alu_ovf}, 64'd1);
    chk("head_kept", {27'd0, _cdb_rob_id, _cdb_value}, {27'd0, 5'd10, 32'd11});

    // push and pop together while full
    _cdb_grant = 1'b1;
    issue(5'd14, T_R, 4'b0010, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b1);
    _cdb_grant = 1'b0;
    chk("full_after_pp", {63'd0, _alu_full}, 64'd1);
    drain();
    chk("full_after_drain", {63'd0, _alu_full}, 64'd0);

    // flush with same-cycle push
    issue(5'd20, T_R, 4'b0000, 32'd1, 32'd0, 32'd1, 1'b1);
    issue(5'd21, T_R, 4'b0000, 32'd2, 32'd0, 32'd2, 1'b1);
    issue(5'd22, T_R, 4'b0000, 32'd3, 32'd0, 32'd3, 1'b1);
    _clear = 1'b1;
    issue(5'd23, T_R, 4'b0000, 32'd4, 32'd0, 32'd4, 1'b0);
    _clear = 1'b0;
    sb.delete();
    chk("clear_empty", {63'd0, _cdb_ready}, 64'd0);
    chk("clear_flags", {62'd0, _alu_full, _alu_ovf}, 64'd1);

    // async reset mid-drain
    issue(5'd24, T_R, 4'b0000, 32'd24, 32'd0, 32'd24, 1'b1);
    issue(5'd25, T_R, 4'b0000, 32'd25, 32'd0, 32'd25, 1'b1);
    _cdb_grant = 1'b1;
    step();
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_ready", {63'd0, _cdb_ready}, 64'd0);
    chk("arst_value", {27'd0, _cdb_rob_id, _cdb_value}, 64'd0);
    chk("arst_flags", {62'd0, _alu_full, _alu_ovf}, 64'd0);
    sb.delete();
    _cdb_grant = 1'b0;
    step();
    rst_n_in = 1'b1;
    step();

    // rdy_in low freezes head and blocks push and pop
    issue(5'd26, T_R, 4'b0000, 32'h0000_1000, 32'h0000_0234, 32'h0000_1234, 1'b1);
    rdy_in = 1'b0;
    _cdb_grant = 1'b1;
    _alu_ready = 1'b1; _alu_rob_id = 5'd27;
    step();
    step();
    chk("frz_head", {26'd0, _cdb_ready, _cdb_rob_id, _cdb_value}, {26'd0, 1'b1, 5'd26, 32'h0000_1234});
    _alu_ready = 1'b0;
    rdy_in = 1'b1;
    step();
    _cdb_grant = 1'b0;
    chk("frz_no_push", {63'd0, _cdb_ready}, 64'd0);
    chk("sb_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
